// File: rtl/audio_dac_sink.sv
// audio_dac_sink: codec-side responder for the stereo sample-write handshake.
// Frames {left, right} are buffered in a small FIFO and shifted out MSB first,
// left-justified, on AUD_DACDAT under control of the external AUD_BCLK and
// AUD_DACLRCK, which are synchronised into the clk domain before use.
module audio_dac_sink #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ACCEPT_GAP = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        write_s,
    input  logic [DATA_W-1:0]           writedata_left,
    input  logic [DATA_W-1:0]           writedata_right,
    output logic                        write_ready,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = $clog2(ACCEPT_GAP + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_L    = GAP_W'(ACCEPT_GAP);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(DATA_W);

    logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [2*DATA_W-1:0] head_frame;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_nxt;
    logic [LVL_W-1:0]    level_nxt;

    // Synchroniser stages: _p0/_p1 resolve metastability, _p2 is edge history
    logic bclk_p0, bclk_p1, bclk_p2;
    logic lrck_p0, lrck_p1, lrck_p2;
    logic bclk_fall, lrck_fall, lrck_rise;

    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   hold_right;
    logic [CNT_W-1:0]    bit_cnt;

    assign bclk_fall  = bclk_p2 & ~bclk_p1;
    assign lrck_fall  = lrck_p2 & ~lrck_p1;
    assign lrck_rise  = ~lrck_p2 & lrck_p1;

    // write_ready is already low when full, so a push can never overflow
    assign push       = write_s & write_ready;
    assign pop        = lrck_fall & (fifo_level != '0);
    assign head_frame = fifo_mem[rd_ptr];

    // Next FIFO occupancy and accept-gap count for this cycle's push/pop
    always_comb begin
        level_nxt = fifo_level;
        gap_nxt   = gap_cnt;
        case ({push, pop})
            2'b10:   level_nxt = fifo_level + 1'b1;
            2'b01:   level_nxt = fifo_level - 1'b1;
            default: level_nxt = fifo_level;
        endcase
        if (push) begin
            gap_nxt = GAP_L;
        end else if (gap_cnt != '0) begin
            gap_nxt = gap_cnt - 1'b1;
        end
    end

    // Bring the asynchronous codec clocks into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {bclk_p2, bclk_p1, bclk_p0} <= 3'b000;
            {lrck_p2, lrck_p1, lrck_p0} <= 3'b000;
        end else begin
            {bclk_p2, bclk_p1, bclk_p0} <= {bclk_p1, bclk_p0, AUD_BCLK};
            {lrck_p2, lrck_p1, lrck_p0} <= {lrck_p1, lrck_p0, AUD_DACLRCK};
        end
    end

    // FIFO pointers, occupancy, accept gap, registered ready and sticky underrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            gap_cnt     <= '0;
            write_ready <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level  <= level_nxt;
            gap_cnt     <= gap_nxt;
            write_ready <= (gap_nxt == '0) && (level_nxt < DEPTH_L);
            if (lrck_fall && (fifo_level == '0)) underrun <= 1'b1;
        end
    end

    // Frame storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {writedata_left, writedata_right};
    end

    // Serialiser: LRCK edges load a channel word (and win over a BCLK edge),
    // each BCLK fall presents the next bit, then zeros once the word is out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            hold_right <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (lrck_fall) begin
            if (fifo_level != '0) begin
                shreg      <= head_frame[2*DATA_W-1:DATA_W];
                hold_right <= head_frame[DATA_W-1:0];
                AUD_DACDAT <= head_frame[2*DATA_W-1];
            end else begin
                shreg      <= '0;
                hold_right <= '0;
                AUD_DACDAT <= 1'b0;
            end
            bit_cnt <= '0;
        end else if (lrck_rise) begin
            shreg      <= hold_right;
            AUD_DACDAT <= hold_right[DATA_W-1];
            bit_cnt    <= '0;
        end else if (bclk_fall) begin
            shreg <= shreg << 1;
            if (bit_cnt < LAST_BIT) begin
                AUD_DACDAT <= shreg[DATA_W-2];
                bit_cnt    <= bit_cnt + 1'b1;
            end else begin
                AUD_DACDAT <= 1'b0;
                bit_cnt    <= DONE_CNT;
            end
        end
    end

endmodule

// File: doc/audio_dac_sink.md
Name: audio_dac_sink

Overview:
- Responder end of the codec sample-write handshake (write_s / write_ready / writedata_left / writedata_right) used by the flash playback controller.
- Accepts stereo 16-bit samples into a small frame FIFO.
- Serializes each frame onto AUD_DACDAT, MSB first, left-justified, timed by the externally supplied AUD_BCLK and AUD_DACLRCK.
- Serves as the synthesizable codec-side model for simulation and as the drop-in DAC path.

Parameters:
- DATA_W, 16: bits per channel sample.
- FIFO_DEPTH, 8: stereo frames buffered; must be a power of 2, at least 2.
- ACCEPT_GAP, 2: cycles write_ready is forced low after each accepted write; must be at least 1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst_n  input  1  synchronous active-low reset.
- write_s  input  1  write strobe, level-sensitive.
- writedata_left  input  DATA_W  left sample.
- writedata_right  input  DATA_W  right sample.
- write_ready  output  1  sink can accept a frame this cycle.
- AUD_BCLK  input  1  bit clock, asynchronous to clk.
- AUD_DACLRCK  input  1  channel select, asynchronous to clk; 0 = left, 1 = right.
- AUD_DACDAT  output  1  serial DAC data.
- fifo_level  output  clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun  output  1  sticky flag: a frame was needed while the FIFO was empty.

Behaviour:
- Reset: all outputs are sampled on the clk edge with rst_n=0. Reset values: write_ready=0, AUD_DACDAT=0, fifo_level=0, underrun=0. FIFO pointers, gap counter, shift register and synchronizers are all cleared.
- write_ready stays 0 during the first cycle after rst_n rises.
- Reset asserted mid-frame discards all FIFO contents and the current shift state.
- Accept rule: a frame is pushed on any clk edge where write_s=1 and write_ready=1. The stored frame is {writedata_left, writedata_right}.
- Gap after accept:
  - The gap counter loads ACCEPT_GAP on each accept.
  - write_ready=0 while the counter is nonzero; the counter decrements each cycle.
  - Otherwise write_ready = (fifo_level < FIFO_DEPTH).
  - write_s held high across the gap is never double-accepted.
- Full: write_ready=0; write_s is ignored and the FIFO is unchanged.
- Synchronization: AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchronizer plus one history flop. Edges are detected in the clk domain, so latency from the pin to the detected edge is 3 clk cycles.
- LRCK falling edge (start of left half):
  - If fifo_level>0, pop one frame: load the left word into the shift register and hold the right word in a holding register.
  - If the FIFO is empty, load zeros into both and set underrun=1. underrun clears only on reset.
  - AUD_DACDAT = left MSB on the cycle after the edge is detected.
- LRCK rising edge: load the held right word; AUD_DACDAT = right MSB on the next cycle. No FIFO pop.
- Each detected BCLK falling edge shifts one bit. After DATA_W bits have been output in a half-frame, AUD_DACDAT=0 until the next LRCK edge.
- LRCK edge and BCLK falling edge detected in the same cycle: the LRCK load wins and the bit counter restarts at 0.
- Simultaneous push and pop in one cycle: both occur, so fifo_level is unchanged. A push into a full FIFO is impossible because write_ready=0; a push with a pop in that cycle is still refused when full.
- Pointers are clog2(FIFO_DEPTH)-bit read/write indices that wrap modulo FIFO_DEPTH. fifo_level is a separate up/down counter with range 0..FIFO_DEPTH.
- Data is passed through bit-exact, with no scaling or sign handling.

Test Plan:
- Reset release, then write_s=1 held constantly with data L=16'h1234, R=16'hABCD, and no LRCK activity. Required: exactly one accept per ACCEPT_GAP+1 cycles; fifo_level climbs to 8, then write_ready stays 0.
- Playback master handshake (write_s asserted on write_ready, held until write_ready seen low): push L=16'h8001/R=16'h7FFE, then L=16'h0001/R=16'hFFFF. Required: exactly two frames stored, no duplicates.
- Preload one frame L=16'hA5A5, R=16'h5A5A; drive BCLK at clk/8 and LRCK at BCLK/32. Required: AUD_DACDAT shows 1010010110100101 in the left half and 0101101001011010 in the right half; fifo_level drops 1 to 0 at the LRCK fall; underrun stays 0.
- Empty FIFO at an LRCK falling edge. Required: AUD_DACDAT=0 for the whole frame, underrun=1, and underrun remains 1 after later pushes.
- With fifo_level=3, push on the same cycle an LRCK fall is detected. Required: fifo_level stays 3 and the popped frame is the oldest.
- Assert rst_n=0 mid-left-word with fifo_level=5. Required: the next cycle shows fifo_level=0, AUD_DACDAT=0, write_ready=0 and underrun=0; after release, normal accepts resume.
